parity_mmio_afu: RTL and testbench
==================================

# parity_mmio_afu

Parametrised CAPI accelerator function unit (AFU) front-end. It implements the PSL job control handshake, an MMIO register file of NUM_REGS 64-bit registers, and odd-parity generation and checking on MMIO data. It sits directly under the PSL boundary and is the base that compute AFUs in this design extend.

## Interface
Parameters:
- NUM_REGS, 8, number of 64-bit MMIO registers (4..256, power of two).
- PARITY_EN, 1, 1 = generate and check odd parity; 0 = parity outputs 0, no checking.

Ports:
- clock  in  1  sole clock; all logic is synchronous to its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- timebase_request  out  1  tied 0.
- parity_enabled  out  1  constant PARITY_EN.
- job_valid  in  1  job command strobe, one cycle.
- job_command  in  8  0x90 = START, 0x80 = RESET; all other values are ignored.
- job_running  out  1  high while the job is active.
- job_done  out  1  one-cycle completion pulse.
- mmio_valid  in  1  MMIO request strobe, one cycle.
- mmio_read  in  1  1 = read, 0 = write.
- mmio_dw  in  1  1 = 64-bit access, 0 = 32-bit access.
- mmio_cfg  in  1  1 = AFU descriptor space access.
- mmio_address  in  24  word address, 32-bit granularity.
- mmio_wdata  in  64  write data.
- mmio_wdata_parity  in  1  odd parity of mmio_wdata.
- mmio_ack  out  1  one-cycle acknowledge.
- mmio_rdata  out  64  read data; valid only while mmio_ack is high.
- mmio_rdata_parity  out  1  odd parity of mmio_rdata.

## Operation
- Register index: idx = mmio_address[log2(NUM_REGS):1]. Bits above that range must be 0, otherwise the access is out of range.
- Register map:
  - reg0 CTRL: writing bit0 = 1 while RUNNING finishes the job; reads return 0.
  - reg1 STATUS: read-only; {47'b0, perr_count[15:0], job_running}.
  - reg2..NUM_REGS-1: read/write scratch.
- 32-bit access:
  - Write: address[0] selects the upper (1) or lower (0) half; the other half is unchanged. Data is taken from mmio_wdata[31:0].
  - Read: rdata = {half, half}.
- 64-bit access: address[0] must be 0. If address[0] = 1, the write is dropped and the read returns 0.
- Out-of-range access and any mmio_cfg access: acked; reads return 64'h0; writes are dropped.
- Write parity check (PARITY_EN = 1): if mmio_wdata_parity != ~^mmio_wdata:
  - the write is dropped;
  - perr_count increments, saturating at 16'hFFFF;
  - the access is still acked.
- Read parity: mmio_rdata_parity = ~^mmio_rdata when PARITY_EN = 1, else 0.
- Job FSM states: IDLE, RUNNING, DONE, RESETTING.
  - IDLE + START → RUNNING.
  - RUNNING + CTRL bit0 write → DONE.
  - DONE → IDLE after 1 cycle; job_done is high for that cycle.
  - Any state + RESET → RESETTING.
  - RESETTING → IDLE after 1 cycle; job_done is high for that cycle.
  - START in RUNNING, DONE or RESETTING is ignored.
- Job RESET clears all registers and perr_count. It does not drop an MMIO ack already in flight.
- reset_n low: FSM goes to IDLE; all registers, perr_count and all outputs are 0 (parity_enabled stays PARITY_EN). No job_done pulse is produced.
- MMIO is serviced in every FSM state.

## Timing
- mmio_valid sampled at edge N → mmio_ack, mmio_rdata and mmio_rdata_parity registered and high for the cycle after edge N+1. Latency 1 cycle.
- A write takes effect at edge N+1, so a read issued in cycle N+1 returns the new value.
- Back-to-back requests every cycle are supported.
- Job command sampled at edge N → job_running rises after edge N+1.
- CTRL finish write at edge N → job_running falls and job_done is high after edge N+1, for one cycle.
- RESET at edge N → job_done high after edge N+2, for one cycle.
- Simultaneous RESET and MMIO write in the same cycle: RESET wins; the register ends at 0.
- perr_count and STATUS update in the same cycle as the ack.

## Test plan
- Reset: hold reset_n low for 3 cycles → all outputs 0; read reg1 → rdata 0, ack 1 cycle after request.
- 64-bit write 0xDEADBEEF_01234567 to reg2 (addr 4, parity 1), read addr 4 → same data, mmio_rdata_parity 1.
- 32-bit write 0xAAAA5555 to addr 5, then 64-bit read addr 4 → 0xAAAA5555_01234567. 32-bit read addr 5 → 0xAAAA5555_AAAA5555.
- Bad-parity write 0x1 to reg3 → reg3 unchanged, STATUS[16:1] = 1. With PARITY_EN = 0 the same write lands and rdata_parity is 0.
- START → job_running 1; write CTRL = 1 → job_running 0 and a single job_done pulse; repeated START → running again.
- RESET while RUNNING with scratch registers nonzero → job_done 2 cycles later; all registers read 0; job_running 0. Out-of-range read (addr 0x800) → 0, acked.

Source files
------------

// File: rtl/parity_mmio_afu.sv
// CAPI AFU front-end: PSL job FSM, MMIO register file
// and odd-parity generation/checking on MMIO data.
module parity_mmio_afu #(
  parameter int NUM_REGS  = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        timebase_request,
  output logic        parity_enabled,
  input  logic        job_valid,
  input  logic [7:0]  job_command,
  output logic        job_running,
  output logic        job_done,
  input  logic        mmio_valid,
  input  logic        mmio_read,
  input  logic        mmio_dw,
  input  logic        mmio_cfg,
  input  logic [23:0] mmio_address,
  input  logic [63:0] mmio_wdata,
  input  logic        mmio_wdata_parity,
  output logic        mmio_ack,
  output logic [63:0] mmio_rdata,
  output logic        mmio_rdata_parity
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_DONE,
    ST_RESETTING
  } state_t;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rpar_q, rpar_d;
  logic [15:0] perr_q, perr_d;
  logic [63:0] regs_q [NUM_REGS];
  logic [63:0] regs_d [NUM_REGS];

  logic [AW-1:0] idx;
  logic          half_hi;
  logic          in_range;
  logic          acc_ok;
  logic          par_ok;
  logic          wr;
  logic          rd;
  logic          wr_ok;
  logic          finish;
  logic          job_start;
  logic          job_reset;
  logic [63:0]   rsel;
  logic [31:0]   half;

  assign timebase_request  = 1'b0;
  assign parity_enabled    = PARITY_EN;
  assign job_running       = (state_q == ST_RUNNING);
  assign job_done          = done_q;
  assign mmio_ack          = ack_q;
  assign mmio_rdata        = rdata_q;
  assign mmio_rdata_parity = rpar_q;

  always_comb begin
    idx       = mmio_address[AW:1];
    half_hi   = mmio_address[0];
    in_range  = (mmio_address >> (AW + 1)) == 24'd0;
    acc_ok    = in_range && !mmio_cfg
                && !(mmio_dw && half_hi);
    par_ok    = !PARITY_EN
                || (mmio_wdata_parity == ~^mmio_wdata);
    wr        = mmio_valid && !mmio_read;
    rd        = mmio_valid && mmio_read;
    wr_ok     = wr && acc_ok && par_ok;
    finish    = wr_ok && (idx == '0) && !half_hi
                && mmio_wdata[0];
    job_start = job_valid && (job_command == 8'h90);
    job_reset = job_valid && (job_command == 8'h80);
  end

  always_comb begin
    rsel = regs_q[idx];
    unique case (1'b1)
      (idx == '0): rsel = 64'd0;
      (idx == AW'(1)): rsel = {47'd0, perr_q, job_running};
      default: ;
    endcase
    half    = half_hi ? rsel[63:32] : rsel[31:0];
    rdata_d = 64'd0;
    if (rd && acc_ok) begin
      rdata_d = mmio_dw ? rsel : {half, half};
    end
    rpar_d = PARITY_EN && rd && ~^rdata_d;
    ack_d  = mmio_valid;
  end

  always_comb begin
    regs_d = regs_q;
    perr_d = perr_q;
    if (wr_ok && (idx[AW-1:1] != '0)) begin
      if (mmio_dw) begin
        regs_d[idx] = mmio_wdata;
      end else if (half_hi) begin
        regs_d[idx][63:32] = mmio_wdata[31:0];
      end else begin
        regs_d[idx][31:0] = mmio_wdata[31:0];
      end
    end
    if (wr && !par_ok && (perr_q != 16'hFFFF)) begin
      perr_d = perr_q + 16'd1;
    end
    // job RESET overrides any same-cycle write
    if (job_reset) begin
      regs_d = '{default: '0};
      perr_d = 16'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (job_start) state_d = ST_RUNNING;
      ST_RUNNING:   if (finish) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      ST_RESETTING: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (job_reset) begin
      state_d = ST_RESETTING;
    end
    done_d = (state_d == ST_DONE)
             || (state_q == ST_RESETTING);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 64'd0;
      rpar_q  <= 1'b0;
      perr_q  <= 16'd0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rpar_q  <= rpar_d;
      perr_q  <= perr_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_parity_mmio_afu.sv
// Directed bench for parity_mmio_afu; instance a has
// parity enabled, instance b has it disabled.
module tb_parity_mmio_afu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        job_valid;
  logic [7:0]  job_command;
  logic        mmio_valid;
  logic        mmio_read;
  logic        mmio_dw;
  logic        mmio_cfg;
  logic [23:0] mmio_address;
  logic [63:0] mmio_wdata;
  logic        mmio_wdata_parity;

  logic        tb_a, tb_b, pe_a, pe_b;
  logic        run_a, run_b, done_a, done_b;
  logic        ack_a, ack_b, rp_a, rp_b;
  logic [63:0] rd_a, rd_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  parity_mmio_afu #(.NUM_REGS(8), .PARITY_EN(1'b1)) u_a (
    .clock(clock), .reset_n(reset_n),
    .timebase_request(tb_a), .parity_enabled(pe_a),
    .job_valid(job_valid), .job_command(job_command),
    .job_running(run_a), .job_done(done_a),
    .mmio_valid(mmio_valid), .mmio_read(mmio_read),
    .mmio_dw(mmio_dw), .mmio_cfg(mmio_cfg),
    .mmio_address(mmio_address), .mmio_wdata(mmio_wdata),
    .mmio_wdata_parity(mmio_wdata_parity),
    .mmio_ack(ack_a), .mmio_rdata(rd_a),
    .mmio_rdata_parity(rp_a)
  );

  parity_mmio_afu #(.NUM_REGS(8), .PARITY_EN(1'b0)) u_b (
    .clock(clock), .reset_n(reset_n),
    .timebase_request(tb_b), .parity_enabled(pe_b),
    .job_valid(job_valid), .job_command(job_command),
    .job_running(run_b), .job_done(done_b),
    .mmio_valid(mmio_valid), .mmio_read(mmio_read),
    .mmio_dw(mmio_dw), .mmio_cfg(mmio_cfg),
    .mmio_address(mmio_address), .mmio_wdata(mmio_wdata),
    .mmio_wdata_parity(mmio_wdata_parity),
    .mmio_ack(ack_b), .mmio_rdata(rd_b),
    .mmio_rdata_parity(rp_b)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic mmio(input logic rd, input logic dw,
                      input logic cfg,
                      input logic [23:0] addr,
                      input logic [63:0] wd,
                      input logic bad);
    mmio_valid        = 1'b1;
    mmio_read         = rd;
    mmio_dw           = dw;
    mmio_cfg          = cfg;
    mmio_address      = addr;
    mmio_wdata        = wd;
    mmio_wdata_parity = bad ? ^wd : ~^wd;
    @(posedge clock);
    #1;
    chk("ack_a", {63'd0, ack_a}, 64'd1);
    chk("ack_b", {63'd0, ack_b}, 64'd1);
    mmio_valid = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic dw,
                       input logic [23:0] addr,
                       input logic [63:0] exp,
                       input logic exp_par);
    mmio(1'b1, dw, 1'b0, addr, 64'd0, 1'b0);
    chk(tag, rd_a, exp);
    chk({tag, "_par"}, {63'd0, rp_a}, {63'd0, exp_par});
  endtask

  task automatic job(input logic [7:0] cmd);
    job_valid   = 1'b1;
    job_command = cmd;
    @(posedge clock);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n           = 1'b0;
    job_valid         = 1'b0;
    job_command       = 8'h00;
    mmio_valid        = 1'b0;
    mmio_read         = 1'b0;
    mmio_dw           = 1'b0;
    mmio_cfg          = 1'b0;
    mmio_address      = 24'd0;
    mmio_wdata        = 64'd0;
    mmio_wdata_parity = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outs_a",
        {58'd0, tb_a, run_a, done_a, ack_a, rp_a, |rd_a},
        64'd0);
    chk("rst_outs_b",
        {58'd0, tb_b, run_b, done_b, ack_b, rp_b, |rd_b},
        64'd0);
    chk("pe", {62'd0, pe_a, pe_b}, 64'd2);
    reset_n = 1'b1;

    rdchk("status_rst", 1'b1, 24'd2, 64'd0, 1'b1);
    tick();
    chk("ack_drop", {63'd0, ack_a}, 64'd0);

    mmio(1'b0, 1'b1, 1'b0, 24'd4,
         64'hDEADBEEF_01234567, 1'b0);
    rdchk("r2_64", 1'b1, 24'd4,
          64'hDEADBEEF_01234567, 1'b1);
    mmio(1'b0, 1'b0, 1'b0, 24'd5,
         64'h00000000_AAAA5555, 1'b0);
    rdchk("r2_mix", 1'b1, 24'd4,
          64'hAAAA5555_01234567, 1'b1);
    rdchk("r2_hi32", 1'b0, 24'd5,
          64'hAAAA5555_AAAA5555, 1'b1);
    rdchk("r2_lo32", 1'b0, 24'd4,
          64'h01234567_01234567, 1'b1);

    mmio(1'b0, 1'b1, 1'b0, 24'd6, 64'd1, 1'b1);
    rdchk("r3_bad", 1'b1, 24'd6, 64'd0, 1'b1);
    chk("r3_nopar_b", rd_b, 64'd1);
    chk("r3_nopar_bp", {63'd0, rp_b}, 64'd0);
    rdchk("status_perr", 1'b1, 24'd2, 64'd2, 1'b0);
    chk("status_b", rd_b, 64'd0);

    rdchk("misalign", 1'b1, 24'd5, 64'd0, 1'b1);
    mmio(1'b1, 1'b1, 1'b1, 24'd4, 64'd0, 1'b0);
    chk("cfg_rd", rd_a, 64'd0);

    job(8'h11);
    chk("bad_cmd", {63'd0, run_a}, 64'd0);
    job(8'h90);
    chk("start_run", {63'd0, run_a}, 64'd1);
    chk("start_done", {63'd0, done_a}, 64'd0);
    rdchk("status_run", 1'b1, 24'd2, 64'd3, 1'b1);

    mmio(1'b0, 1'b1, 1'b0, 24'd0, 64'd1, 1'b0);
    chk("fin_run", {63'd0, run_a}, 64'd0);
    chk("fin_done", {63'd0, done_a}, 64'd1);
    chk("fin_done_b", {63'd0, done_b}, 64'd1);
    tick();
    chk("fin_pulse", {63'd0, done_a}, 64'd0);
    rdchk("ctrl_rd", 1'b1, 24'd0, 64'd0, 1'b1);

    job(8'h90);
    chk("restart", {63'd0, run_a}, 64'd1);
    job(8'h80);
    chk("rst_run", {63'd0, run_a}, 64'd0);
    chk("rst_done1", {63'd0, done_a}, 64'd0);
    tick();
    chk("rst_done2", {63'd0, done_a}, 64'd1);
    tick();
    chk("rst_done3", {63'd0, done_a}, 64'd0);
    rdchk("r2_clr", 1'b1, 24'd4, 64'd0, 1'b1);
    rdchk("r3_clr_a", 1'b1, 24'd6, 64'd0, 1'b1);
    chk("r3_clr_b", rd_b, 64'd0);
    rdchk("status_clr", 1'b1, 24'd2, 64'd0, 1'b1);
    rdchk("oor", 1'b1, 24'h800, 64'd0, 1'b1);

    mmio(1'b0, 1'b1, 1'b0, 24'd8, 64'h55, 1'b0);
    rdchk("r4_wr", 1'b1, 24'd8, 64'h55, 1'b1);
    job_valid   = 1'b1;
    job_command = 8'h80;
    mmio(1'b0, 1'b1, 1'b0, 24'd8, 64'h1234, 1'b0);
    job_valid = 1'b0;
    rdchk("r4_race", 1'b1, 24'd8, 64'd0, 1'b1);
    chk("race_run", {63'd0, run_a}, 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
